clk_div_ctrl: RTL

- Run-time controller for the odd/even integer clock divider.
- Holds the active divisor and starts and stops the divided clock.
- Applies new divisor requests only at an output-period boundary, so clk_out never shows a runt pulse or a truncated period.
- Produces a 50%-duty divided clock for any N >= 2, plus a period-start tick for downstream sequencing.

---
 rtl/clk_div_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the integer clock divider: holds the divisor, starts/stops
// the divided clock and swaps divisors only at period boundaries.
//   state | meaning
//   IDLE  | divider stopped, clk_out low, divisor loads apply directly
//   RUN   | counting, no request pending
//   PEND  | counting, new divisor waits for the wrap edge
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic [CNT_W-1:0] div_active,
  output logic             clk_out,
  output logic             tick
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] pend, pend_n;
  logic [CNT_W-1:0] div_n;
  logic             hi_q, hi_n;
  logic             neg_q;
  logic             tick_n, err_n;
  logic             wrap, val_ok;

  assign val_ok = (div_val >= TWO);
  assign wrap   = (state != IDLE) && (cnt == div_active - ONE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    div_n   = div_active;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (div_load) begin
          if (val_ok) div_n = div_val;
          else        err_n = 1'b1;
        end
        // Start one count short of the wrap so the next edge opens the first period.
        if (enable) begin
          state_n = RUN;
          cnt_n   = div_n - ONE;
        end
      end
      RUN: begin
        cnt_n = wrap ? '0 : cnt + ONE;
        if (div_load && !val_ok) err_n = 1'b1;
        if (wrap && !enable) begin
          state_n = IDLE;
          if (div_load && val_ok) div_n = div_val;
        end else if (div_load && val_ok) begin
          pend_n  = div_val;
          state_n = PEND;
        end
      end
      PEND: begin
        cnt_n = wrap ? '0 : cnt + ONE;
        if (div_load) err_n = 1'b1;
        if (wrap) begin
          div_n   = pend;
          state_n = enable ? RUN : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    tick_n = (state_n != IDLE) && (cnt_n == '0);
    hi_n   = (state_n != IDLE) && (cnt_n < (div_n >> 1));
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= '0;
      div_active <= DIV_RST;
      div_err    <= 1'b0;
      tick       <= 1'b0;
      hi_q       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      div_active <= div_n;
      div_err    <= err_n;
      tick       <= tick_n;
      hi_q       <= hi_n;
    end
  end

  // Half-cycle copy of hi_q stretches the high phase for odd divisors.
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= hi_q;
  end

  assign clk_out  = hi_q | (div_active[0] & neg_q);
  assign div_busy = (state == PEND);

endmodule
